// File: rtl/uart_mmio_ctrl.sv
// MMIO controller for the Riscv151 memory stage: UART RX FIFO, TX holding register
// and cycle/instret counters, with registered (1-cycle) read data.
module uart_mmio_ctrl #(
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_en,
  input  logic [7:0]  io_addr,
  input  logic        io_re,
  input  logic [3:0]  io_we,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic        inst_retired,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_FIFO_DEPTH);

  localparam logic [5:0] W_CTRL = 6'h00;
  localparam logic [5:0] W_RXD  = 6'h01;
  localparam logic [5:0] W_TXD  = 6'h02;
  localparam logic [5:0] W_CYC  = 6'h04;
  localparam logic [5:0] W_INST = 6'h05;
  localparam logic [5:0] W_CRST = 6'h06;

  typedef enum logic {TX_EMPTY, TX_FULL} tx_state_t;

  logic [5:0]    word;
  logic          rd_req, wr_req;
  logic          ctrl_wr, txd_wr, crst_wr, rxd_rd;
  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_nonempty, fifo_full, push_ok, pop, ovf_set;
  logic          rx_ovf, tx_drop;
  tx_state_t     tx_state, tx_state_nxt;
  logic          tx_load, tx_drop_set;
  logic [31:0]   cyc_cnt, inst_cnt;
  logic [31:0]   rdata_p0;
  logic          unused_bits;

  assign word    = io_addr[7:2];
  assign rd_req  = io_en & io_re;
  assign wr_req  = io_en & (|io_we);
  assign ctrl_wr = wr_req & (word == W_CTRL);
  assign txd_wr  = wr_req & (word == W_TXD);
  assign crst_wr = wr_req & (word == W_CRST);
  assign rxd_rd  = rd_req & (word == W_RXD);

  assign rx_ready    = 1'b1;
  assign unused_bits = ^{io_addr[1:0], io_wdata[31:8]};

  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == FULL_CNT);
  assign pop           = rxd_rd & fifo_nonempty;
  // A pop frees the slot the simultaneous push lands in, so full+pop still accepts.
  assign push_ok       = rx_valid & (~fifo_full | pop);
  assign ovf_set       = rx_valid & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    tx_drop_set  = 1'b0;
    case (tx_state)
      TX_EMPTY: begin
        if (txd_wr) begin
          tx_state_nxt = TX_FULL;
          tx_load      = 1'b1;
        end
      end
      TX_FULL: begin
        if (tx_ready) begin
          if (txd_wr) tx_load = 1'b1;
          else        tx_state_nxt = TX_EMPTY;
        end else if (txd_wr) begin
          tx_drop_set = 1'b1;
        end
      end
      default: tx_state_nxt = TX_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_EMPTY;
      tx_data  <= 8'h00;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_load) tx_data <= io_wdata[7:0];
    end
  end

  assign tx_valid = (tx_state == TX_FULL);

  // Sticky flags: a new error event in the same cycle as a CTRL write takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf  <= 1'b0;
      tx_drop <= 1'b0;
    end else begin
      if (ovf_set)          rx_ovf <= 1'b1;
      else if (ctrl_wr)     rx_ovf <= 1'b0;
      if (tx_drop_set)      tx_drop <= 1'b1;
      else if (ctrl_wr)     tx_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || crst_wr) begin
      cyc_cnt  <= 32'd0;
      inst_cnt <= 32'd0;
    end else begin
      cyc_cnt  <= cyc_cnt + 32'd1;
      inst_cnt <= inst_cnt + {31'd0, inst_retired};
    end
  end

  // Stage p0: read mux on request-cycle state
  always_comb begin
    rdata_p0 = 32'd0;
    case (word)
      W_CTRL:  rdata_p0 = {28'd0, tx_drop, rx_ovf, fifo_nonempty, (tx_state == TX_EMPTY)};
      W_RXD:   rdata_p0 = fifo_nonempty ? {24'd0, mem[rd_ptr]} : 32'd0;
      W_CYC:   rdata_p0 = cyc_cnt;
      W_INST:  rdata_p0 = inst_cnt;
      default: rdata_p0 = 32'd0;
    endcase
  end

  // Stage p1: registered read data, held when no request
  always_ff @(posedge clk) begin
    if (rst)         io_rdata <= 32'd0;
    else if (rd_req) io_rdata <= rdata_p0;
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: directed vector table, hand sequences for FIFO/TX/counter
// corners, and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_mmio_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_en;
  logic [7:0]  io_addr;
  logic        io_re;
  logic [3:0]  io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        inst_retired;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int vectors = 0;
  int miscompares = 0;

  uart_mmio_ctrl #(.RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .io_en(io_en), .io_addr(io_addr), .io_re(io_re),
    .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .inst_retired(inst_retired), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_ovf, m_drop, m_txv;
  logic [7:0]  m_txd;
  logic [31:0] m_cyc, m_inst, m_rdata;

  task automatic model_step(input logic s_rst, input logic s_en, input logic [7:0] s_addr,
                            input logic s_re, input logic [3:0] s_we, input logic [31:0] s_wd,
                            input logic s_rxv, input logic [7:0] s_rxd, input logic s_txr,
                            input logic s_inst);
    logic rd, wr, hs;
    logic [5:0] w;
    logic [31:0] rv;
    if (s_rst) begin
      m_q.delete();
      m_ovf = 0; m_drop = 0; m_txv = 0; m_txd = 0;
      m_cyc = 0; m_inst = 0; m_rdata = 0;
      return;
    end
    rd = s_en && s_re;
    wr = s_en && (s_we != 0);
    w  = s_addr[7:2];
    rv = 0;
    case (w)
      6'd0: rv = {28'd0, m_drop, m_ovf, (m_q.size() != 0), !m_txv};
      6'd1: if (m_q.size() != 0) rv = {24'd0, m_q[0]};
      6'd4: rv = m_cyc;
      6'd5: rv = m_inst;
      default: rv = 0;
    endcase
    hs = m_txv && s_txr;
    if (rd) m_rdata = rv;
    if (wr && w == 6'd0) begin m_ovf = 0; m_drop = 0; end
    if (rd && w == 6'd1 && m_q.size() != 0) void'(m_q.pop_front());
    if (s_rxv) begin
      if (m_q.size() < DEPTH) m_q.push_back(s_rxd);
      else m_ovf = 1;
    end
    if (wr && w == 6'd2) begin
      if (!m_txv || hs) begin m_txd = s_wd[7:0]; m_txv = 1; end
      else m_drop = 1;
    end else if (hs) begin
      m_txv = 0;
    end
    if (wr && w == 6'd6) begin
      m_cyc = 0; m_inst = 0;
    end else begin
      m_cyc = m_cyc + 1;
      m_inst = m_inst + {31'd0, s_inst};
    end
  endtask

  task automatic tick();
    logic s_rst, s_en, s_re, s_rxv, s_txr, s_inst;
    logic [7:0] s_addr, s_rxd;
    logic [3:0] s_we;
    logic [31:0] s_wd;
    s_rst = rst; s_en = io_en; s_addr = io_addr; s_re = io_re; s_we = io_we;
    s_wd = io_wdata; s_rxv = rx_valid; s_rxd = rx_data; s_txr = tx_ready; s_inst = inst_retired;
    @(posedge clk);
    model_step(s_rst, s_en, s_addr, s_re, s_we, s_wd, s_rxv, s_rxd, s_txr, s_inst);
    #1;
  endtask

  task automatic idle();
    rst = 0; io_en = 0; io_addr = 0; io_re = 0; io_we = 0; io_wdata = 0;
    rx_valid = 0; rx_data = 0; tx_ready = 0; inst_retired = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); idle();
  endtask

  task automatic rd(input logic [7:0] a);
    io_en = 1; io_re = 1; io_addr = a; tick(); idle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_en = 1; io_we = 4'hF; io_addr = a; io_wdata = d; tick(); idle();
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1; rx_data = b; tick(); idle();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic [7:0]  addr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [31:0] exp_rdata;
    logic        exp_txv;
    logic [7:0]  exp_txd;
  } vec_t;

  function automatic vec_t mk(logic en, logic [7:0] addr, logic re, logic [3:0] we,
                              logic [31:0] wdata, logic rxv, logic [7:0] rxd, logic txr,
                              logic [31:0] er, logic ev, logic [7:0] ed);
    vec_t v;
    v.en = en; v.addr = addr; v.re = re; v.we = we; v.wdata = wdata; v.rxv = rxv;
    v.rxd = rxd; v.txr = txr; v.exp_rdata = er; v.exp_txv = ev; v.exp_txd = ed;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;

    //           en   addr  re  we    wdata   rxv  rxd   txr  rdata  txv  txd
    tbl[0]  = mk(1, 8'h00, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h1,  0, 8'h00);
    tbl[1]  = mk(0, 8'h00, 0, 4'h0, 32'h0,  1, 8'h61, 0, 32'h1,  0, 8'h00);
    tbl[2]  = mk(0, 8'h00, 0, 4'h0, 32'h0,  1, 8'h62, 0, 32'h1,  0, 8'h00);
    tbl[3]  = mk(0, 8'h00, 0, 4'h0, 32'h0,  1, 8'h63, 0, 32'h1,  0, 8'h00);
    tbl[4]  = mk(1, 8'h00, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h3,  0, 8'h00);
    tbl[5]  = mk(1, 8'h04, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h61, 0, 8'h00);
    tbl[6]  = mk(1, 8'h04, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h62, 0, 8'h00);
    tbl[7]  = mk(1, 8'h04, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h63, 0, 8'h00);
    tbl[8]  = mk(1, 8'h00, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h1,  0, 8'h00);
    tbl[9]  = mk(1, 8'h04, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h0,  0, 8'h00);
    tbl[10] = mk(1, 8'h08, 0, 4'hF, 32'h55, 0, 8'h00, 0, 32'h0,  1, 8'h55);
    tbl[11] = mk(1, 8'h00, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h0,  1, 8'h55);
    tbl[12] = mk(1, 8'h08, 0, 4'hF, 32'h66, 0, 8'h00, 0, 32'h0,  1, 8'h55);
    tbl[13] = mk(1, 8'h00, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h8,  1, 8'h55);
    tbl[14] = mk(0, 8'h00, 0, 4'h0, 32'h0,  0, 8'h00, 1, 32'h8,  0, 8'h55);
    tbl[15] = mk(1, 8'h00, 0, 4'h1, 32'hFFFF_FFFF, 0, 8'h00, 0, 32'h8, 0, 8'h55);
    tbl[16] = mk(1, 8'h00, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h1,  0, 8'h55);
    tbl[17] = mk(1, 8'h0C, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h0,  0, 8'h55);
    tbl[18] = mk(1, 8'h00, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h1,  0, 8'h55);
    tbl[19] = mk(1, 8'h08, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h0,  0, 8'h55);
    tbl[20] = mk(1, 8'h00, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h1,  0, 8'h55);
    tbl[21] = mk(0, 8'h10, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h1,  0, 8'h55);
    tbl[22] = mk(0, 8'h08, 0, 4'hF, 32'h77, 0, 8'h00, 0, 32'h1,  0, 8'h55);
    tbl[23] = mk(1, 8'h1C, 1, 4'h0, 32'h0,  0, 8'h00, 0, 32'h0,  0, 8'h55);

    tick();
    idle();
    check("reset_rdata", io_rdata, 32'h0);
    check("reset_txv", {31'd0, tx_valid}, 32'h0);
    check("reset_txd", {24'd0, tx_data}, 32'h0);
    check("rx_ready", {31'd0, rx_ready}, 32'h1);

    for (int i = 0; i < 24; i++) begin
      io_en = tbl[i].en; io_addr = tbl[i].addr; io_re = tbl[i].re; io_we = tbl[i].we;
      io_wdata = tbl[i].wdata; rx_valid = tbl[i].rxv; rx_data = tbl[i].rxd; tx_ready = tbl[i].txr;
      tick();
      idle();
      check($sformatf("tbl%0d_rdata", i), io_rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_txv", i), {31'd0, tx_valid}, {31'd0, tbl[i].exp_txv});
      check($sformatf("tbl%0d_txd", i), {24'd0, tx_data}, {24'd0, tbl[i].exp_txd});
    end

    // Post-reset CTRL and a cycle counter window
    do_reset();
    rd(8'h00);
    check("t1_ctrl", io_rdata, 32'h1);
    repeat (5) tick();
    rd(8'h10);
    vectors++;
    if (io_rdata < 32'd5 || io_rdata > 32'd7) begin
      miscompares++;
      $display("FAIL t1_cyc: got %0d expected 5..7", io_rdata);
    end

    // Overflow with the TX register held full
    wr(8'h08, 32'hAA);
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    rd(8'h00);
    check("t3_ctrl_ovf", io_rdata, 32'h6);
    for (int i = 0; i < 8; i++) begin
      rd(8'h04);
      check($sformatf("t3_rxd%0d", i), io_rdata, 32'h10 + 32'(i));
    end
    rd(8'h00);
    check("t3_ctrl_sticky", io_rdata, 32'h4);
    wr(8'h00, 32'h0);
    rd(8'h00);
    check("t3_ctrl_clr", io_rdata, 32'h0);
    check("t3_txd_held", {24'd0, tx_data}, 32'hAA);
    tx_ready = 1; tick(); idle();
    check("t3_txv_drain", {31'd0, tx_valid}, 32'h0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    io_en = 1; io_re = 1; io_addr = 8'h04; rx_valid = 1; rx_data = 8'h38;
    tick(); idle();
    check("t6_pop_head", io_rdata, 32'h30);
    rd(8'h00);
    check("t6_ctrl", io_rdata, 32'h3);
    for (int i = 0; i < 8; i++) begin
      rd(8'h04);
      check($sformatf("t6_rxd%0d", i), io_rdata, 32'h31 + 32'(i));
    end
    rd(8'h04);
    check("t6_empty", io_rdata, 32'h0);

    // Instruction counter and clear-beats-increment
    wr(8'h18, 32'h0);
    for (int i = 0; i < 10; i++) begin inst_retired = 1; tick(); idle(); end
    rd(8'h14);
    check("t5_inst10", io_rdata, 32'd10);
    inst_retired = 1; io_en = 1; io_we = 4'hF; io_addr = 8'h18; tick(); idle();
    rd(8'h14);
    check("t5_inst_clr", io_rdata, 32'd0);
    rd(8'h10);
    check("t5_cyc_small", io_rdata, 32'd1);

    // Reset in the middle of activity
    wr(8'h08, 32'h99);
    push(8'hA1); push(8'hA2);
    rst = 1; io_en = 1; io_re = 1; io_addr = 8'h10; tick(); idle();
    check("rst_rdata", io_rdata, 32'h0);
    check("rst_txv", {31'd0, tx_valid}, 32'h0);
    check("rst_txd", {24'd0, tx_data}, 32'h0);
    rd(8'h00);
    check("rst_ctrl", io_rdata, 32'h1);
    rd(8'h04);
    check("rst_fifo", io_rdata, 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] addrs[8];
      addrs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C};
      rst = ($urandom_range(0, 249) == 0);
      io_en = ($urandom_range(0, 3) != 0);
      io_addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 7)];
      io_re = 1'($urandom);
      io_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      io_wdata = $urandom;
      rx_valid = (c < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      rx_data = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      inst_retired = 1'($urandom);
      tick();
      check($sformatf("rnd%0d_rdata", c), io_rdata, m_rdata);
      check($sformatf("rnd%0d_txv", c), {31'd0, tx_valid}, {31'd0, m_txv});
      check($sformatf("rnd%0d_txd", c), {24'd0, tx_data}, {24'd0, m_txd});
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
